// File: rtl/latency_memory.sv
// latency_memory: byte-addressed simulation memory with three independent
// latency-timed channels (instruction fetch, data fetch, data write).
// Optional bounds checking is enabled by defining MEM_BOUNDS_CHECK_EN;
// otherwise addresses wrap modulo MEM_BYTES and the err outputs stay 0.

// One channel's IDLE/WAIT/DONE handshake timer. 'fire' marks the edge that
// enters DONE (read capture / write error decision point).
module latency_memory_chan #(
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  output logic fire,
  output logic done
);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // State and down-counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; req is ignored while in DONE so back-to-back pulses never occur
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (req) begin
        if (LATENCY == 1) begin
          state_d = DONE;
          fire    = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = CW'(LATENCY - 1);
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          fire    = 1'b1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

module latency_memory #(
  parameter  int ADDR_WIDTH    = 32,
  parameter  int DATA_WIDTH    = 32,
  parameter  int MEM_BYTES     = 4096,
  parameter  int READ_LATENCY  = 2,
  parameter  int WRITE_LATENCY = 3,
  localparam int DATA_BYTES    = DATA_WIDTH / 8,
  localparam int BYTES_W       = $clog2(DATA_BYTES) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifetch_req,
  input  logic [ADDR_WIDTH-1:0] ifetch_addr,
  output logic [DATA_WIDTH-1:0] ifetch_data,
  output logic                  ifetch_done,
  output logic                  ifetch_err,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic [DATA_WIDTH-1:0] fetch_data,
  output logic                  fetch_done,
  output logic                  fetch_err,
  input  logic                  write_req,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [BYTES_W-1:0]    write_bytes,
  output logic                  write_done,
  output logic                  write_err
);
  localparam int NUM_RD = 2;
  localparam int MAW    = $clog2(MEM_BYTES);
  localparam int XW     = ADDR_WIDTH + 1;

  logic [7:0] mem [MEM_BYTES];

  // Read lanes: 0 = instruction fetch, 1 = data fetch
  logic [NUM_RD-1:0]                 rd_req, rd_done, rd_err;
  logic [NUM_RD-1:0][ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_data;

  assign rd_req  = {fetch_req, ifetch_req};
  assign rd_addr = {fetch_addr, ifetch_addr};

  for (genvar c = 0; c < NUM_RD; c++) begin : g_rd
    logic                  fire, oob, err_q;
    logic [DATA_WIDTH-1:0] word, data_q;

    latency_memory_chan #(.LATENCY(READ_LATENCY)) u_chan (
      .clk  (clk),
      .rst  (rst),
      .req  (rd_req[c]),
      .fire (fire),
      .done (rd_done[c])
    );

    // Little-endian gather of DATA_BYTES bytes from the wrapped address
    always_comb begin
      word = '0;
      for (int i = 0; i < DATA_BYTES; i++)
        word[8*i +: 8] = mem[MAW'(rd_addr[c] + ADDR_WIDTH'(i))];
    end

`ifdef MEM_BOUNDS_CHECK_EN
    assign oob = (XW'(rd_addr[c]) + XW'(DATA_BYTES)) > XW'(MEM_BYTES);
`else
    assign oob = 1'b0;
`endif

    // Capture on the edge entering DONE; the register holds until the next one
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_q <= '0;
        err_q  <= 1'b0;
      end else if (fire) begin
        data_q <= oob ? '0 : word;
        err_q  <= oob;
      end
    end

    assign rd_data[c] = data_q;
    assign rd_err[c]  = err_q;
  end

  assign ifetch_data = rd_data[0];
  assign ifetch_done = rd_done[0];
  assign ifetch_err  = rd_err[0];
  assign fetch_data  = rd_data[1];
  assign fetch_done  = rd_done[1];
  assign fetch_err   = rd_err[1];

  // Write lane
  logic               wr_fire, wr_done, wr_oob, wr_err_q;
  logic [BYTES_W-1:0] wr_cnt;

  latency_memory_chan #(.LATENCY(WRITE_LATENCY)) u_wr_chan (
    .clk  (clk),
    .rst  (rst),
    .req  (write_req),
    .fire (wr_fire),
    .done (wr_done)
  );

  // Byte counts above DATA_BYTES saturate
  assign wr_cnt = (write_bytes > BYTES_W'(DATA_BYTES)) ? BYTES_W'(DATA_BYTES) : write_bytes;

`ifdef MEM_BOUNDS_CHECK_EN
  assign wr_oob = (wr_cnt != '0) && ((XW'(write_addr) + XW'(wr_cnt)) > XW'(MEM_BYTES));
`else
  assign wr_oob = 1'b0;
`endif

  // Error decided when entering DONE so it is stable for the whole done cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          wr_err_q <= 1'b0;
    else if (wr_fire) wr_err_q <= wr_oob;
  end

  // Commit at the edge closing the DONE cycle; the array itself is never reset,
  // and a reset before that edge drops wr_done so the write is cancelled
  always_ff @(posedge clk) begin
    if (wr_done && !wr_err_q) begin
      for (int i = 0; i < DATA_BYTES; i++)
        if (BYTES_W'(i) < wr_cnt)
          mem[MAW'(write_addr + ADDR_WIDTH'(i))] <= write_data[8*i +: 8];
    end
  end

  assign write_done = wr_done;
  assign write_err  = wr_err_q;
endmodule

// File: tb/tb_latency_memory.sv
// Bench for latency_memory: directed stimulus plus a cycle-level reference
// model (byte array + per-channel request timeline) checked every cycle.
module tb_latency_memory;
  localparam int AW = 32, DW = 32, MB = 4096, RL = 2, WL = 3, DB = 4, BW = 3;

  logic          clk = 1'b0, rst = 1'b1;
  logic          ifetch_req, fetch_req, write_req;
  logic [AW-1:0] ifetch_addr, fetch_addr, write_addr;
  logic [DW-1:0] ifetch_data, fetch_data, write_data;
  logic          ifetch_done, ifetch_err, fetch_done, fetch_err, write_done, write_err;
  logic [BW-1:0] write_bytes;

  latency_memory #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_BYTES(MB),
    .READ_LATENCY(RL), .WRITE_LATENCY(WL)
  ) dut (
    .clk(clk), .rst(rst),
    .ifetch_req(ifetch_req), .ifetch_addr(ifetch_addr), .ifetch_data(ifetch_data),
    .ifetch_done(ifetch_done), .ifetch_err(ifetch_err),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_data(fetch_data),
    .fetch_done(fetch_done), .fetch_err(fetch_err),
    .write_req(write_req), .write_addr(write_addr), .write_data(write_data),
    .write_bytes(write_bytes), .write_done(write_done), .write_err(write_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [MB];
  bit         known   [MB];
  int         st [3] = '{-1, -1, -1};   // cycle each channel's request was accepted
  int         cyc = 0;
  bit         pend, new_pend;
  logic [31:0] pend_a, pend_d, new_a, new_d;
  int         pend_n, new_n;

  function automatic int eff_bytes(input logic [BW-1:0] b);
    return (int'(b) > DB) ? DB : int'(b);
  endfunction

  function automatic bit oob(input logic [31:0] a, input int n);
`ifdef MEM_BOUNDS_CHECK_EN
    return (n > 0) && (64'(a) + 64'(n) > 64'(MB));
`else
    return 1'b0;
`endif
  endfunction

  function automatic int widx(input logic [31:0] a, input int i);
    return int'((a + 32'(i)) % MB);
  endfunction

  function automatic bit rd_known(input logic [31:0] a);
    for (int i = 0; i < DB; i++) if (!known[widx(a, i)]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] w;
    for (int i = 0; i < DB; i++) w[8*i +: 8] = ref_mem[widx(a, i)];
    return w;
  endfunction

  logic [2:0]  crq, cdn, cer;
  logic [31:0] cad [3];
  logic [31:0] cdt [2];
  int          lat_m;
  bit          exp_done, exp_err;

  // Compare process: a request accepted in cycle s completes in cycle s+LAT;
  // a write finishing in cycle w is visible to captures from edge w+2 on.
  always @(negedge clk) begin
    cyc++;
    new_pend = 1'b0;
    if (rst) begin
      chk("rst_ifetch_data", ifetch_data, 32'h0);
      chk("rst_fetch_data", fetch_data, 32'h0);
      chk("rst_flags", 32'({ifetch_done, ifetch_err, fetch_done, fetch_err, write_done, write_err}), 32'h0);
      st = '{-1, -1, -1};
    end else begin
      crq = {write_req, fetch_req, ifetch_req};
      cdn = {write_done, fetch_done, ifetch_done};
      cer = {write_err, fetch_err, ifetch_err};
      cad[0] = ifetch_addr; cad[1] = fetch_addr; cad[2] = write_addr;
      cdt[0] = ifetch_data; cdt[1] = fetch_data;
      for (int c = 0; c < 3; c++) begin
        lat_m    = (c == 2) ? WL : RL;
        exp_done = (st[c] >= 0) && (cyc - st[c] == lat_m);
        chk($sformatf("done_ch%0d_cyc%0d", c, cyc), 32'(cdn[c]), 32'(exp_done));
        if (exp_done) begin
          st[c] = -1;
          if (c < 2) begin
            exp_err = oob(cad[c], DB);
            chk($sformatf("err_ch%0d", c), 32'(cer[c]), 32'(exp_err));
            if (exp_err) chk($sformatf("oob_data_ch%0d", c), cdt[c], 32'h0);
            else if (rd_known(cad[c]))
              chk($sformatf("data_ch%0d_a%0h", c, cad[c]), cdt[c], ref_word(cad[c]));
          end else begin
            new_n   = eff_bytes(write_bytes);
            exp_err = oob(write_addr, new_n);
            chk("write_err", 32'(write_err), 32'(exp_err));
            if (!exp_err) begin
              new_pend = 1'b1; new_a = write_addr; new_d = write_data;
            end
          end
        end else if (st[c] < 0 && crq[c]) begin
          st[c] = cyc;
        end
      end
    end
    if (pend)
      for (int i = 0; i < pend_n; i++) begin
        ref_mem[widx(pend_a, i)] = pend_d[8*i +: 8];
        known[widx(pend_a, i)]   = 1'b1;
      end
    pend = new_pend; pend_a = new_a; pend_d = new_d; pend_n = new_n;
  end

  // ---------------- stimulus ----------------
  task automatic rd(input int ch, input logic [31:0] a,
                    output logic [31:0] d, output logic e, output int lat);
    @(posedge clk); #1;
    if (ch == 0) begin ifetch_addr = a; ifetch_req = 1'b1; end
    else         begin fetch_addr  = a; fetch_req  = 1'b1; end
    lat = -1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if ((ch == 0) ? ifetch_done : fetch_done) begin lat = k; break; end
    end
    d = (ch == 0) ? ifetch_data : fetch_data;
    e = (ch == 0) ? ifetch_err : fetch_err;
    @(posedge clk); #1;
    ifetch_req = 1'b0; fetch_req = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input int n,
                    output logic e, output int lat);
    @(posedge clk); #1;
    write_addr = a; write_data = d; write_bytes = BW'(n); write_req = 1'b1;
    lat = -1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (write_done) begin lat = k; break; end
    end
    e = write_err;
    @(posedge clk); #1;
    write_req = 1'b0;
  endtask

  logic [31:0] d;
  logic        e;
  int          lat, pulses, consec, first;
  bit          prev, seen;

  initial begin
    ifetch_req = 0; fetch_req = 0; write_req = 0;
    ifetch_addr = 0; fetch_addr = 0; write_addr = 0; write_data = 0; write_bytes = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Background contents used by later reads
    wr(32'h104, 32'h0, 4, e, lat);
    wr(32'hFFC, 32'h44332211, 4, e, lat);
    wr(32'h000, 32'h88776655, 4, e, lat);

    // Full write then read back
    wr(32'h100, 32'hDEADBEEF, 4, e, lat);
    chk("wr_latency", 32'(lat), 32'(WL));
    chk("wr_err", 32'(e), 32'h0);
    rd(1, 32'h100, d, e, lat);
    chk("rd_latency", 32'(lat), 32'(RL));
    chk("rd_deadbeef", d, 32'hDEADBEEF);

    // Unaligned partial write straddling a word boundary
    wr(32'h103, 32'h0000AA55, 2, e, lat);
    rd(1, 32'h100, d, e, lat);
    chk("rd_partial_100", d, 32'h55ADBEEF);
    rd(1, 32'h104, d, e, lat);
    chk("rd_partial_104", d, 32'h000000AA);

    // Concurrent: reads complete with the pre-write bytes
    @(posedge clk); #1;
    ifetch_addr = 32'h100; fetch_addr = 32'h104;
    write_addr = 32'h100; write_data = 32'h12345678; write_bytes = 3'd4;
    ifetch_req = 1'b1; fetch_req = 1'b1; write_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("conc_done", 32'({ifetch_done, fetch_done, write_done}), 32'b110);
    chk("conc_ifetch_old", ifetch_data, 32'h55ADBEEF);
    chk("conc_fetch_old", fetch_data, 32'h000000AA);
    @(posedge clk); #1;
    ifetch_req = 1'b0; fetch_req = 1'b0;
    @(negedge clk);
    chk("conc_wdone", 32'(write_done), 32'h1);
    @(posedge clk); #1;
    write_req = 1'b0;
    rd(0, 32'h100, d, e, lat);
    chk("conc_refetch", d, 32'h12345678);

    // Held request: one pulse every RL+1 cycles
    @(posedge clk); #1;
    ifetch_addr = 32'h100; ifetch_req = 1'b1;
    pulses = 0; consec = 0; first = -1; prev = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (ifetch_done) begin
        pulses++;
        if (first < 0) first = k;
        if (prev) consec++;
      end
      prev = ifetch_done;
    end
    @(posedge clk); #1;
    ifetch_req = 1'b0;
    chk("hold_pulses", 32'(pulses), 32'd3);
    chk("hold_consec", 32'(consec), 32'd0);
    chk("hold_first", 32'(first), 32'd2);

    // Zero-byte write and saturating byte count
    wr(32'h100, 32'hFFFFFFFF, 0, e, lat);
    chk("wr0_latency", 32'(lat), 32'(WL));
    rd(1, 32'h100, d, e, lat);
    chk("wr0_nochange", d, 32'h12345678);
    wr(32'h300, 32'h01020304, 7, e, lat);
    rd(0, 32'h300, d, e, lat);
    chk("wr7_saturate", d, 32'h01020304);

    // Reset in cycle 1 of a write cancels it
    wr(32'h200, 32'hCAFEF00D, 4, e, lat);
    @(posedge clk); #1;
    write_addr = 32'h200; write_data = 32'h11223344; write_bytes = 3'd4; write_req = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; write_req = 1'b0;
    @(negedge clk);
    chk("rst_wdone", 32'(write_done), 32'h0);
    chk("rst_ifetch_cleared", ifetch_data, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (write_done) seen = 1'b1; end
    chk("rst_no_wdone", 32'(seen), 32'h0);
    rd(0, 32'h200, d, e, lat);
    chk("rst_mem_kept", d, 32'hCAFEF00D);

    // Top-of-array behaviour
    rd(1, 32'hFFE, d, e, lat);
`ifdef MEM_BOUNDS_CHECK_EN
    chk("oob_rd_err", 32'(e), 32'h1);
    chk("oob_rd_data", d, 32'h0);
    wr(32'hFFF, 32'h000000A5, 1, e, lat);
    chk("edge_wr_err", 32'(e), 32'h0);
    wr(32'hFFF, 32'h00005A5A, 2, e, lat);
    chk("oob_wr_err", 32'(e), 32'h1);
    rd(1, 32'hFFC, d, e, lat);
    chk("oob_wr_nochange", d, 32'hA5332211);
`else
    chk("wrap_rd_err", 32'(e), 32'h0);
    chk("wrap_rd_data", d, 32'h66554433);
`endif

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end
endmodule

// File: doc/latency_memory.md
# latency_memory

Parametrised byte-addressed simulation memory with three independent channels: instruction fetch, data fetch and data write. Each channel runs a request/done handshake with a configurable fixed latency, so the core's fetch and load/store stages see realistic multi-cycle memory. Unaligned, multi-byte little-endian accesses are supported, and an optional bounds checker is included.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data width; multiple of 8; DATA_BYTES = DATA_WIDTH/8
- MEM_BYTES, 4096, array size in bytes; power of two
- READ_LATENCY, 2, cycles from first req cycle to done, both read channels; ≥1
- WRITE_LATENCY, 3, cycles from first req cycle to done, write channel; ≥1

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- ifetch_req  in  1  instruction read request
- ifetch_addr  in  ADDR_WIDTH  instruction byte address
- ifetch_data  out  DATA_WIDTH  instruction word, valid while ifetch_done
- ifetch_done  out  1  one-cycle completion pulse
- ifetch_err  out  1  error, valid while ifetch_done
- fetch_req, fetch_addr, fetch_data, fetch_done, fetch_err: same widths/meanings for the data read channel
- write_req  in  1  write request
- write_addr  in  ADDR_WIDTH  first byte address
- write_data  in  DATA_WIDTH  byte i = write_data[8i+:8]
- write_bytes  in  $clog2(DATA_BYTES)+1  byte count, 0..DATA_BYTES
- write_done  out  1  one-cycle pulse; array updated at the posedge ending this cycle
- write_err  out  1  error, valid while write_done

## Operation
- Each channel has its own FSM and down-counter: IDLE, WAIT, DONE.
- IDLE: req=1 → load counter with LATENCY-1, go to WAIT. If LATENCY=1, go straight to DONE.
- WAIT: decrement the counter. At 0, go to DONE:
  - read channels capture array bytes addr..addr+DATA_BYTES-1 into the data register, little-endian;
  - the write channel asserts done.
- DONE: done=1 for exactly one cycle, then IDLE. req is ignored in DONE, so max throughput is one access per LATENCY+1 cycles.
- The requester holds req, addr, data and bytes stable from the first req cycle through the done cycle. Dropping req before done is illegal; the FSM does not abort.
- Write: byte i < write_bytes goes to (write_addr+i). write_bytes=0 completes the handshake with no array change. Values > DATA_BYTES are treated as DATA_BYTES.
- Byte addresses are taken modulo MEM_BYTES (wrap-around) unless bounds checking is enabled.
- The three channels are fully concurrent. A read capture on the same edge as a write commit returns the old bytes.
- Read data registers hold their last value until the next capture.

## Timing
- req first high in cycle n → done high in cycle n+LATENCY only; data and err valid in that cycle.
- Write array update at the posedge ending cycle n+WRITE_LATENCY.
- A read issued in cycle n+WRITE_LATENCY+1 or later sees the written data.
- rst (async, any time): all FSMs → IDLE; counters, done, err and data outputs → 0.
  - Array contents are not cleared.
  - A write whose done has not yet been reached is cancelled with no array change.
- First request is accepted in the first cycle after rst deasserts.

## Configuration
- MEM_BOUNDS_CHECK_EN defined:
  - A read is out of range if addr+DATA_BYTES > MEM_BYTES. It completes with err=1 and data=0.
  - A write is out of range if write_bytes>0 and write_addr+write_bytes > MEM_BYTES. It completes with err=1 and no bytes written.
  - Comparisons are done at ADDR_WIDTH+1 bits.
- MEM_BOUNDS_CHECK_EN undefined: err outputs tied to 0; addresses wrap modulo MEM_BYTES.

## Test plan
Defaults used unless stated.
- Write 0x0000_0100, data 0xDEADBEEF, bytes=4; req cycle 0 → write_done only in cycle 3. Then fetch 0x100 → fetch_done cycle 2 after req, data 0xDEADBEEF.
- Unaligned partial write: addr 0x103, data 0x0000_AA55, bytes=2 → fetch 0x100 returns 0x55ADBEEF, fetch 0x104 low byte 0xAA.
- Concurrent access: ifetch 0x100 and fetch 0x104 in the same cycle as the write to 0x100 → both done together 2 cycles later with pre-write data; a re-fetch of 0x100 after write_done shows the new data.
- Hold req high continuously → done pulses every 3 cycles (READ_LATENCY=2), never on consecutive cycles.
- Assert rst in cycle 1 of a write with WRITE_LATENCY=3 → no write_done; memory unchanged; outputs 0 during reset.
- Bounds, with the macro: fetch 0xFFE → err=1, data=0; write 0xFFF with bytes=1 succeeds, bytes=2 gives err=1 and no change. Without the macro: fetch 0xFFE wraps to bytes 0xFFE, 0xFFF, 0x000, 0x001.
